// File: rtl/exp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exp_ctrl_pkg
// Shared definitions for the exp range-reduction controller:
//   - state_t : controller FSM states
//   - DATA_W  : operand / kernel-argument width ({0,8} fraction)
//   - RES_W   : result width ({2,8} fixed point)
//   - THRESH  : reduction threshold, 0.75 in {0,8}
//   - E_CONST : e in {2,8} (2.71875)
// -----------------------------------------------------------------------------
package exp_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 10;

    localparam logic [DATA_W-1:0] THRESH  = 8'd192;
    localparam logic [RES_W-1:0]  E_CONST = 10'd696;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        SCALE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/exp_range_ctrl_npp_if.sv
// -----------------------------------------------------------------------------
// exp_range_ctrl_npp_if
// Bundles the three handshakes around the controller:
//   operand : x, x_valid (in), x_ready (out)
//   kernel  : k_data, k_sign, k_valid (out), k_result, k_result_valid (in)
//   result  : y, y_valid (out), y_ready (in)
// Modports:
//   master : controller side (drives x_ready, kernel request, result)
//   slave  : environment side (operand source, kernel, result sink)
// -----------------------------------------------------------------------------
interface exp_range_ctrl_npp_if;
    import exp_ctrl_pkg::*;

    logic [DATA_W-1:0] x;
    logic              x_valid;
    logic              x_ready;

    logic [DATA_W-1:0] k_data;
    logic              k_sign;
    logic              k_valid;
    logic [RES_W-1:0]  k_result;
    logic              k_result_valid;

    logic [RES_W-1:0]  y;
    logic              y_valid;
    logic              y_ready;

    modport master (
        input  x, x_valid, k_result, k_result_valid, y_ready,
        output x_ready, k_data, k_sign, k_valid, y, y_valid
    );

    modport slave (
        output x, x_valid, k_result, k_result_valid, y_ready,
        input  x_ready, k_data, k_sign, k_valid, y, y_valid
    );

endinterface

// File: rtl/exp_scale_e.sv
// -----------------------------------------------------------------------------
// exp_scale_e
// Purely combinational rescale of a kernel result by e:
//   p = i_r * E_CONST  ({2,8} x {2,8} -> {4,16}, 20 bits)
//   o_y = p[17:8], saturated to all-ones when p[19:18] is non-zero.
// Ports:
//   i_r : kernel result, {2,8}
//   o_y : rescaled result, {2,8}
// -----------------------------------------------------------------------------
module exp_scale_e
    import exp_ctrl_pkg::*;
(
    input  logic [RES_W-1:0] i_r,
    output logic [RES_W-1:0] o_y
);

    logic [2*RES_W-1:0] w_p;

    assign w_p = (2*RES_W)'(i_r) * (2*RES_W)'(E_CONST);

    // Integer part above two bits cannot be represented in {2,8}.
    assign o_y = (w_p[19:18] != 2'b00) ? '1 : w_p[17:8];

endmodule

// File: rtl/exp_range_ctrl_npp.sv
// -----------------------------------------------------------------------------
// exp_range_ctrl_npp
// Front-end/back-end controller for the non-pipelined exp kernel.
// Accepts x in [0,1), reduces x > 0.75 to t = x - 1 (sent as |t| with sign),
// issues a one-cycle kernel request, waits for the kernel result and, when x
// was reduced, multiplies the result by e. Returns e^x in {2,8}.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : exp_range_ctrl_npp_if.master (operand, kernel and result handshakes)
// -----------------------------------------------------------------------------
module exp_range_ctrl_npp
    import exp_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    exp_range_ctrl_npp_if.master    bus
);

    state_t            r_state;
    state_t            w_next;

    logic [DATA_W-1:0] r_x;
    logic              r_red;
    logic [RES_W-1:0]  r_res;
    logic [RES_W-1:0]  r_y;
    logic              r_y_valid;

    logic [DATA_W-1:0] w_neg_x;
    logic [RES_W-1:0]  w_scaled;

    exp_scale_e u_scale (
        .i_r (r_res),
        .o_y (w_scaled)
    );

    // |x - 1| in {0,8}: 256 - x, low 8 bits.
    assign w_neg_x = DATA_W'(9'h100 - {1'b0, r_x});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.x_valid)         w_next = ISSUE;
            ISSUE:                            w_next = WAIT;
            WAIT:    if (bus.k_result_valid)  w_next = r_red ? SCALE : DONE;
            SCALE:                            w_next = DONE;
            DONE:    if (bus.y_ready)         w_next = IDLE;
            default:                          w_next = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_red     <= 1'b0;
            r_res     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.x_valid) begin
                        r_x   <= bus.x;
                        r_red <= (bus.x > THRESH);
                    end
                end
                WAIT: begin
                    if (bus.k_result_valid) begin
                        if (r_red) begin
                            r_res <= bus.k_result;
                        end else begin
                            r_y       <= bus.k_result;
                            r_y_valid <= 1'b1;
                        end
                    end
                end
                SCALE: begin
                    r_y       <= w_scaled;
                    r_y_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.y_ready) begin
                        r_y_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs. x_ready is gated by rst_n so it reads 0 while reset is held
    // even though the state register already sits in IDLE.
    always_comb begin
        bus.x_ready = (r_state == IDLE) && rst_n;
        bus.k_valid = 1'b0;
        bus.k_data  = '0;
        bus.k_sign  = 1'b0;
        if (r_state == ISSUE) begin
            bus.k_valid = 1'b1;
            bus.k_data  = r_red ? w_neg_x : r_x;
            bus.k_sign  = r_red;
        end
        bus.y       = r_y;
        bus.y_valid = r_y_valid;
    end

endmodule

// File: tb/tb_exp_range_ctrl_npp.sv
// -----------------------------------------------------------------------------
// tb_exp_range_ctrl_npp
// Self-checking bench for exp_range_ctrl_npp with a behavioural kernel model
// (result valid drops on request and rises five cycles later) and a reference
// model computed directly from the reduction / rescale arithmetic.
// -----------------------------------------------------------------------------
module tb_exp_range_ctrl_npp;

    logic clk;
    logic rst_n;

    exp_range_ctrl_npp_if bus ();

    exp_range_ctrl_npp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Kernel model: value returned for the next request.
    logic [9:0] kres;
    int         kcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.k_result       <= '0;
            bus.k_result_valid <= 1'b0;
            kcnt               <= 0;
        end else if (bus.k_valid) begin
            bus.k_result_valid <= 1'b0;
            bus.k_result       <= kres;
            kcnt               <= 4;
        end else if (kcnt != 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) bus.k_result_valid <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x_ready"}, 32'(bus.x_ready), 32'd0);
        check({tag, "_k_valid"}, 32'(bus.k_valid), 32'd0);
        check({tag, "_k_data"},  32'(bus.k_data),  32'd0);
        check({tag, "_k_sign"},  32'(bus.k_sign),  32'd0);
        check({tag, "_y"},       32'(bus.y),       32'd0);
        check({tag, "_y_valid"}, 32'(bus.y_valid), 32'd0);
    endtask

    // Drive x to acceptance; checks the one-cycle request that follows.
    task automatic accept(input logic [7:0] xv, input logic [9:0] kr);
        int guard;
        int xi;
        int e_kd;
        int e_ks;
        xi   = int'(xv);
        e_ks = (xi > 192) ? 1 : 0;
        e_kd = e_ks ? ((256 - xi) % 256) : xi;
        kres = kr;
        @(negedge clk);
        bus.x       = xv;
        bus.x_valid = 1'b1;
        guard = 0;
        while (!bus.x_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_bound", 32'(guard < 20), 32'd1);
        @(posedge clk);
        #1;
        bus.x_valid = 1'b0;
        check("req_k_valid", 32'(bus.k_valid), 32'd1);
        check("req_k_data",  32'(bus.k_data),  32'(e_kd));
        check("req_k_sign",  32'(bus.k_sign),  32'(e_ks));
        check("busy_x_ready", 32'(bus.x_ready), 32'd0);
    endtask

    task automatic run_op(input logic [7:0] xv, input logic [9:0] kr, input int hold);
        int xi;
        int e_y;
        int e_lat;
        int lat;
        xi = int'(xv);
        if (xi > 192) begin
            e_y   = (int'(kr) * 696) / 256;
            if (e_y > 1023) e_y = 1023;
            e_lat = 7;
        end else begin
            e_y   = int'(kr);
            e_lat = 6;
        end
        accept(xv, kr);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                check("post_k_valid", 32'(bus.k_valid), 32'd0);
                check("post_k_data",  32'(bus.k_data),  32'd0);
            end
            if (bus.y_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("y", 32'(bus.y), 32'(e_y));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_y",       32'(bus.y),       32'(e_y));
            check("hold_y_valid", 32'(bus.y_valid), 32'd1);
            check("hold_x_ready", 32'(bus.x_ready), 32'd0);
            check("hold_stale_kv", 32'(bus.k_result_valid), 32'd1);
        end
        @(negedge clk);
        bus.y_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.y_ready = 1'b0;
        check("idle_y_valid", 32'(bus.y_valid), 32'd0);
        check("idle_x_ready", 32'(bus.x_ready), 32'd1);
        check("idle_k_valid", 32'(bus.k_valid), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.x       = '0;
        bus.x_valid = 1'b0;
        bus.y_ready = 1'b0;
        kres        = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_x_ready", 32'(bus.x_ready), 32'd1);

        // Directed cases
        run_op(8'd0,   10'd256,  0);
        run_op(8'd64,  10'd329,  1);
        run_op(8'd224, 10'd226,  0);
        run_op(8'd192, 10'd500,  0);
        run_op(8'd255, 10'd255,  0);
        run_op(8'd200, 10'd1023, 0);
        run_op(8'd193, 10'd0,    0);
        // Backpressure with stale kernel valid
        run_op(8'd100, 10'd777,  10);
        run_op(8'd250, 10'd400,  10);

        // Reset while waiting on the kernel
        accept(8'd64, 10'd329);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_release_x_ready", 32'(bus.x_ready), 32'd1);
        run_op(8'd64, 10'd329, 0);

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            logic [7:0] rx;
            logic [9:0] rk;
            if (n % 2 == 0) rx = 8'($urandom_range(193, 255));
            else            rx = 8'($urandom_range(0, 192));
            rk = 10'($urandom_range(0, 1023));
            run_op(rx, rk, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
